// File: rtl/uart_cmd_ctrl.sv
// Framed host-command sequencer behind uart_recv: HDR, OP, LEN, PAYLOAD[LEN] and optional CHK.
// Define UART_CMD_CHKSUM_EN to include the XOR checksum byte and its CHK state.
//
// state | meaning
// IDLE  | waiting for HDR_BYTE; all other bytes are ignored
// OP    | next byte is the opcode
// LEN   | next byte is the payload length (0..MAX_LEN)
// DATA  | collecting payload bytes
// CHK   | next byte must equal the running XOR (only with UART_CMD_CHKSUM_EN)
// HOLD  | command presented on cmd_*; waits for cmd_ready
module uart_cmd_ctrl #(
  parameter int unsigned CLK_FREQ      = 50_000_000,
  parameter int unsigned UART_BPS      = 115200,
  parameter logic [7:0]  HDR_BYTE      = 8'hA5,
  parameter int unsigned MAX_LEN       = 8,
  parameter int unsigned TIMEOUT_BYTES = 4
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 uart_done,
  input  logic [7:0]           uart_data,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [7:0]           cmd_op,
  output logic [3:0]           cmd_len,
  output logic [8*MAX_LEN-1:0] cmd_payload,
  output logic                 busy,
  output logic                 err_pulse,
  output logic [2:0]           err_code
);

  localparam longint unsigned TMO_LIMIT =
    64'(TIMEOUT_BYTES) * 64'd10 * 64'(CLK_FREQ) / 64'(UART_BPS);
  localparam int TMR_W = $clog2(TMO_LIMIT + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TMO_LIMIT - 1);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  localparam logic [2:0] ERR_TMO = 3'd1;
  localparam logic [2:0] ERR_LEN = 3'd2;
`ifdef UART_CMD_CHKSUM_EN
  localparam logic [2:0] ERR_CHK = 3'd3;
`endif
  localparam logic [2:0] ERR_OVR = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OP,
    S_LEN,
    S_DATA,
`ifdef UART_CMD_CHKSUM_EN
    S_CHK,
`endif
    S_HOLD
  } state_t;

  // State entered once the last payload byte (or a zero length) has been seen.
`ifdef UART_CMD_CHKSUM_EN
  localparam state_t S_TAIL = S_CHK;
`else
  localparam state_t S_TAIL = S_HOLD;
`endif

  state_t               state_q, state_d;
  logic [7:0]           op_q, op_d;
  logic [3:0]           len_q, len_d;
  logic [8*MAX_LEN-1:0] payload_q, payload_d;
  logic [3:0]           idx_q, idx_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic                 err_pulse_q, err_pulse_d;
  logic [2:0]           err_code_q, err_code_d;
  logic                 timed;
  logic                 expire;
`ifdef UART_CMD_CHKSUM_EN
  logic [7:0]           xor_q, xor_d;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      len_q       <= '0;
      payload_q   <= '0;
      idx_q       <= '0;
      tmr_q       <= '0;
      err_pulse_q <= 1'b0;
      err_code_q  <= '0;
`ifdef UART_CMD_CHKSUM_EN
      xor_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      len_q       <= len_d;
      payload_q   <= payload_d;
      idx_q       <= idx_d;
      tmr_q       <= tmr_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
`ifdef UART_CMD_CHKSUM_EN
      xor_q       <= xor_d;
`endif
    end
  end

  // Inter-byte timer: reloaded on every byte, terminal count at zero.
  assign timed  = (state_q != S_IDLE) && (state_q != S_HOLD);
  assign expire = timed && !uart_done && (tmr_q == '0);

  always_comb begin
    tmr_d = tmr_q;
    if (uart_done)
      tmr_d = TMR_LOAD;
    else if (timed && (tmr_q != '0))
      tmr_d = tmr_q - 1'b1;
  end

`ifdef UART_CMD_CHKSUM_EN
  always_comb begin
    xor_d = xor_q;
    if (uart_done) begin
      case (state_q)
        S_IDLE:                xor_d = '0;
        S_OP, S_LEN, S_DATA:   xor_d = xor_q ^ uart_data;
        default:               xor_d = xor_q;
      endcase
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    len_d       = len_q;
    payload_d   = payload_q;
    idx_d       = idx_q;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;

    case (state_q)
      S_IDLE: begin
        if (uart_done && (uart_data == HDR_BYTE)) begin
          op_d      = '0;
          len_d     = '0;
          payload_d = '0;
          state_d   = S_OP;
        end
      end
      S_OP: begin
        if (uart_done) begin
          op_d    = uart_data;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (uart_done) begin
          if (uart_data > MAX_LEN_B) begin
            err_pulse_d = 1'b1;
            err_code_d  = ERR_LEN;
            state_d     = S_IDLE;
          end else begin
            len_d   = uart_data[3:0];
            idx_d   = '0;
            state_d = (uart_data == 8'd0) ? S_TAIL : S_DATA;
          end
        end
      end
      S_DATA: begin
        if (uart_done) begin
          for (int i = 0; i < int'(MAX_LEN); i++)
            if (idx_q == 4'(i))
              payload_d[8*i +: 8] = uart_data;
          idx_d = idx_q + 4'd1;
          if (idx_q == (len_q - 4'd1))
            state_d = S_TAIL;
        end
      end
`ifdef UART_CMD_CHKSUM_EN
      S_CHK: begin
        if (uart_done) begin
          if (uart_data == xor_q) begin
            state_d = S_HOLD;
          end else begin
            err_pulse_d = 1'b1;
            err_code_d  = ERR_CHK;
            state_d     = S_IDLE;
          end
        end
      end
`endif
      S_HOLD: begin
        if (uart_done) begin
          err_pulse_d = 1'b1;
          err_code_d  = ERR_OVR;
        end
        if (cmd_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (expire) begin
      err_pulse_d = 1'b1;
      err_code_d  = ERR_TMO;
      state_d     = S_IDLE;
    end
  end

  assign cmd_valid   = (state_q == S_HOLD);
  assign busy        = (state_q != S_IDLE);
  assign cmd_op      = op_q;
  assign cmd_len     = len_q;
  assign cmd_payload = payload_q;
  assign err_pulse   = err_pulse_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl with byte-time 100 cycles (timeout 400).
// Frames carry a checksum byte when UART_CMD_CHKSUM_EN is defined.
module tb_uart_cmd_ctrl;

  logic        sys_clk;
  logic        sys_rst;
  logic        uart_done;
  logic [7:0]  uart_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_op;
  logic [3:0]  cmd_len;
  logic [63:0] cmd_payload;
  logic        busy;
  logic        err_pulse;
  logic [2:0]  err_code;

  int n_cmp  = 0;
  int n_fail = 0;

  uart_cmd_ctrl #(
    .CLK_FREQ      (1000),
    .UART_BPS      (100),
    .HDR_BYTE      (8'hA5),
    .MAX_LEN       (8),
    .TIMEOUT_BYTES (4)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .uart_done   (uart_done),
    .uart_data   (uart_data),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_len     (cmd_len),
    .cmd_payload (cmd_payload),
    .busy        (busy),
    .err_pulse   (err_pulse),
    .err_code    (err_code)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [7:0] b);
    uart_data = b;
    uart_done = 1'b1;
    tick(1);
    uart_done = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    tick(2);
    strobe(b);
  endtask

  task automatic send_seq(input logic [63:0] seq, input int n);
    for (int k = 0; k < n; k++)
      send(seq[8*(n-1-k) +: 8]);
  endtask

  logic [2:0] exp_code;

  initial begin
    sys_rst   = 1'b1;
    uart_done = 1'b0;
    uart_data = 8'h00;
    cmd_ready = 1'b0;
    tick(2);
    sys_rst = 1'b0;
    tick(1);
    check("rst_valid", cmd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_err_code", err_code, 0);
    check("rst_payload", cmd_payload, 0);

    // 1: good frame with cmd_ready high in advance
    cmd_ready = 1'b1;
`ifdef UART_CMD_CHKSUM_EN
    send_seq(48'hA5_01_02_11_22_30, 6);
`else
    send_seq(40'hA5_01_02_11_22, 5);
`endif
    check("s1_valid", cmd_valid, 1);
    check("s1_op", cmd_op, 8'h01);
    check("s1_len", cmd_len, 4'd2);
    check("s1_payload", cmd_payload, 64'h2211);
    check("s1_err_pulse", err_pulse, 0);
    tick(1);
    check("s1_valid_drop", cmd_valid, 0);
    check("s1_busy_after", busy, 0);

    // 2: oversize length, then zero-length frame
    send_seq(24'hA5_03_09, 3);
    check("s2_err_pulse", err_pulse, 1);
    check("s2_err_code", err_code, 3'd2);
    check("s2_busy", busy, 0);
    check("s2_valid", cmd_valid, 0);
    tick(1);
    check("s2_err_pulse_1cyc", err_pulse, 0);
    check("s2_err_code_held", err_code, 3'd2);
`ifdef UART_CMD_CHKSUM_EN
    send_seq(32'hA5_03_00_03, 4);
`else
    send_seq(24'hA5_03_00, 3);
`endif
    check("s2b_valid", cmd_valid, 1);
    check("s2b_op", cmd_op, 8'h03);
    check("s2b_len", cmd_len, 4'd0);
    check("s2b_payload", cmd_payload, 64'h0);
    tick(1);
    check("s2b_valid_drop", cmd_valid, 0);

    // 3: timeout boundary
    send(8'hA5);
    strobe(8'h01);
    tick(398);
    check("s3_no_early_tmo", err_pulse, 0);
    strobe(8'h02);
    check("s3_byte399_busy", busy, 1);
    check("s3_byte399_no_err", err_pulse, 0);
    tick(399);
    check("s3_pre_expiry_busy", busy, 1);
    check("s3_pre_expiry_err", err_pulse, 0);
    tick(1);
    check("s3_tmo_pulse", err_pulse, 1);
    check("s3_tmo_code", err_code, 3'd1);
    check("s3_tmo_busy", busy, 0);
    exp_code = 3'd1;

    // 4: bad checksum, then junk in IDLE
`ifdef UART_CMD_CHKSUM_EN
    send_seq(48'hA5_01_02_11_22_31, 6);
    check("s4_chk_pulse", err_pulse, 1);
    check("s4_chk_code", err_code, 3'd3);
    check("s4_chk_valid", cmd_valid, 0);
    check("s4_chk_busy", busy, 0);
    exp_code = 3'd3;
`endif
    send(8'h00);
    check("s4_junk00_pulse", err_pulse, 0);
    send(8'hFF);
    check("s4_junkFF_pulse", err_pulse, 0);
    check("s4_junk_busy", busy, 0);
    check("s4_junk_code", err_code, exp_code);

    // 5: overrun while holding
    cmd_ready = 1'b0;
`ifdef UART_CMD_CHKSUM_EN
    send_seq(40'hA5_07_01_5A_5C, 5);
`else
    send_seq(32'hA5_07_01_5A, 4);
`endif
    check("s5_valid", cmd_valid, 1);
    tick(20);
    check("s5_valid_wait", cmd_valid, 1);
    strobe(8'h55);
    check("s5_ovr_pulse", err_pulse, 1);
    check("s5_ovr_code", err_code, 3'd4);
    check("s5_ovr_valid", cmd_valid, 1);
    check("s5_ovr_payload", cmd_payload, 64'h5A);
    check("s5_ovr_op", cmd_op, 8'h07);
    check("s5_ovr_len", cmd_len, 4'd1);
    tick(1);
    check("s5_ovr_pulse_drop", err_pulse, 0);
    check("s5_still_valid", cmd_valid, 1);
    cmd_ready = 1'b1;
    tick(1);
    check("s5_xfer_valid", cmd_valid, 0);
    check("s5_xfer_busy", busy, 0);

    // 6: reset mid-DATA, then a full frame
    send_seq(32'hA5_02_03_AA, 4);
    check("s6_mid_busy", busy, 1);
    sys_rst = 1'b1;
    tick(1);
    sys_rst = 1'b0;
    check("s6_rst_busy", busy, 0);
    check("s6_rst_valid", cmd_valid, 0);
    check("s6_rst_code", err_code, 0);
    check("s6_rst_pulse", err_pulse, 0);
    check("s6_rst_op", cmd_op, 0);
    check("s6_rst_len", cmd_len, 0);
    check("s6_rst_payload", cmd_payload, 0);
`ifdef UART_CMD_CHKSUM_EN
    send_seq(56'hA5_02_03_AA_BB_CC_DC, 7);
`else
    send_seq(48'hA5_02_03_AA_BB_CC, 6);
`endif
    check("s6_valid", cmd_valid, 1);
    check("s6_op", cmd_op, 8'h02);
    check("s6_len", cmd_len, 4'd3);
    check("s6_payload", cmd_payload, 64'hCCBBAA);
    tick(1);
    check("s6_done", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
